// File: rtl/sgpio_pkg.sv
// Shared constants and types for the SGPIO target receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sgpio_pkg;
    localparam int BITS_PER_DRV = 3;
    localparam int IDX_ACT      = 0;
    localparam int IDX_LOC      = 1;
    localparam int IDX_FAIL     = 2;
    localparam int ERR_W        = 8;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/sgpio_rx_multi_if.sv
// SGPIO pin bundle plus decoded per-drive status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; status outputs are level signals.
interface sgpio_rx_multi_if
    import sgpio_pkg::*;
#(
    parameter int NUM_DRV = 36
);
    logic               SCLK;
    logic               SLOAD;
    logic               SDATA;
    logic [NUM_DRV-1:0] ACT;
    logic [NUM_DRV-1:0] LOC;
    logic [NUM_DRV-1:0] FAIL;
    logic               FRAME_VALID;
    logic               LINK_UP;
    logic [ERR_W-1:0]   ERR_CNT;

    modport master (
        output SCLK, SLOAD, SDATA,
        input  ACT, LOC, FAIL, FRAME_VALID, LINK_UP, ERR_CNT
    );

    modport slave (
        input  SCLK, SLOAD, SDATA,
        output ACT, LOC, FAIL, FRAME_VALID, LINK_UP, ERR_CNT
    );
endinterface

// File: rtl/sgpio_sync_edge.sv
// 2-flop synchroniser for SCLK/SLOAD/SDATA with registered SCLK rising-edge detect.
// Latency: sclk_re and the aligned sload_s/sdata_s appear 3 clk cycles after the pins.
// Backpressure: none.
module sgpio_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic sload,
    input  logic sdata,
    output logic sclk_re,
    output logic sload_s,
    output logic sdata_s
);
    logic [1:0] sclk_m;
    logic [1:0] sload_m;
    logic [1:0] sdata_m;
    logic       sclk_d;

    // The third stage registers the edge together with SLOAD/SDATA so all three stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_m  <= '0;
            sload_m <= '0;
            sdata_m <= '0;
            sclk_d  <= 1'b0;
            sclk_re <= 1'b0;
            sload_s <= 1'b0;
            sdata_s <= 1'b0;
        end else begin
            sclk_m  <= {sclk_m[0], sclk};
            sload_m <= {sload_m[0], sload};
            sdata_m <= {sdata_m[0], sdata};
            sclk_d  <= sclk_m[1];
            sclk_re <= sclk_m[1] & ~sclk_d;
            sload_s <= sload_m[1];
            sdata_s <= sdata_m[1];
        end
    end
endmodule

// File: rtl/sgpio_rx_multi.sv
// SGPIO target receiver: frame decode, length check, link watchdog, short-frame counter (SGPIO_ACT_STRETCH_EN adds ACT stretching).
// Latency: commit/FRAME_VALID 4 SYSCLK cycles after the terminating SLOAD edge at the pins.
// Backpressure: none; outputs are level registers, FRAME_VALID a 1-cycle pulse.
module sgpio_rx_multi
    import sgpio_pkg::*;
#(
    parameter int NUM_DRV      = 36,
    parameter int TIMEOUT_CYC  = 2_500_000,
    parameter int STRETCH_TICK = 1_250_000
) (
    input  logic              SYSCLK,
    input  logic              RESET,
    sgpio_rx_multi_if.slave   bus
);
    localparam int NBITS = BITS_PER_DRV * NUM_DRV;
    localparam int CNT_W = $clog2(NBITS + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] NBITS_C = CNT_W'(NBITS);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYC - 1);

    if (NUM_DRV < 1 || NUM_DRV > 64 || TIMEOUT_CYC < 2 || STRETCH_TICK < 1) begin : g_bad_param
        $error("sgpio_rx_multi: parameter out of range");
    end

    logic               sclk_re, sload_s, sdata_s;
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [NBITS-1:0]   shreg;
    logic [WD_W-1:0]    wd_cnt;
    logic               wd_exp;
    logic               start_bit, store_bit, commit, short_err;
    logic [NUM_DRV-1:0] act_q, loc_q, fail_q;
    logic               fv_q, link_q;
    logic [ERR_W-1:0]   err_q;

    sgpio_sync_edge u_sync (
        .clk     (SYSCLK),
        .rst     (RESET),
        .sclk    (bus.SCLK),
        .sload   (bus.SLOAD),
        .sdata   (bus.SDATA),
        .sclk_re (sclk_re),
        .sload_s (sload_s),
        .sdata_s (sdata_s)
    );

    // An edge in the expiry cycle keeps the link alive.
    assign wd_exp = (wd_cnt == WD_MAX) && !sclk_re;

    always_ff @(posedge SYSCLK) begin
        if (RESET || sclk_re)    wd_cnt <= '0;
        else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) state <= HUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_bit = 1'b0;
        store_bit = 1'b0;
        commit    = 1'b0;
        short_err = 1'b0;
        if (wd_exp) begin
            state_nxt = HUNT;
        end else if (sclk_re) begin
            case (state)
                HUNT: begin
                    if (sload_s) begin
                        start_bit = 1'b1;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sload_s) begin
                        start_bit = 1'b1;
                        commit    = (bit_cnt == NBITS_C);
                        short_err = (bit_cnt != NBITS_C);
                    end else if (bit_cnt != NBITS_C) begin
                        store_bit = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Commit reads the old shift register while the new frame's bit 0 is written.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            bit_cnt <= '0;
            shreg   <= '0;
            act_q   <= '0;
            loc_q   <= '0;
            fail_q  <= '0;
            fv_q    <= 1'b0;
            link_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            fv_q <= commit;
            if (wd_exp) begin
                bit_cnt <= '0;
                act_q   <= '0;
                loc_q   <= '0;
                fail_q  <= '0;
                link_q  <= 1'b0;
            end else begin
                if (start_bit) begin
                    shreg[0] <= sdata_s;
                    bit_cnt  <= CNT_W'(1);
                end else if (store_bit) begin
                    shreg[bit_cnt] <= sdata_s;
                    bit_cnt        <= bit_cnt + 1'b1;
                end
                if (commit) begin
                    for (int d = 0; d < NUM_DRV; d++) begin
                        act_q[d]  <= shreg[d*BITS_PER_DRV + IDX_ACT];
                        loc_q[d]  <= shreg[d*BITS_PER_DRV + IDX_LOC];
                        fail_q[d] <= shreg[d*BITS_PER_DRV + IDX_FAIL];
                    end
                    link_q <= 1'b1;
                end
                if (short_err && err_q != {ERR_W{1'b1}}) err_q <= err_q + 1'b1;
            end
        end
    end

`ifdef SGPIO_ACT_STRETCH_EN
    localparam int PS_W = (STRETCH_TICK > 1) ? $clog2(STRETCH_TICK) : 1;
    logic [PS_W-1:0]    ps_cnt;
    logic               tick;
    logic [1:0]         str_cnt [NUM_DRV];
    logic [NUM_DRV-1:0] str_on;

    assign tick = (ps_cnt == PS_W'(STRETCH_TICK - 1));

    always_ff @(posedge SYSCLK) begin
        if (RESET || tick) ps_cnt <= '0;
        else               ps_cnt <= ps_cnt + 1'b1;
    end

    // A fresh commit reloads even when a tick lands in the same cycle.
    always_ff @(posedge SYSCLK) begin
        for (int d = 0; d < NUM_DRV; d++) begin
            if (RESET || wd_exp)
                str_cnt[d] <= 2'd0;
            else if (commit && shreg[d*BITS_PER_DRV + IDX_ACT])
                str_cnt[d] <= 2'd3;
            else if (tick && str_cnt[d] != 2'd0)
                str_cnt[d] <= str_cnt[d] - 2'd1;
        end
    end

    always_comb begin
        str_on = '0;
        for (int d = 0; d < NUM_DRV; d++) str_on[d] = (str_cnt[d] != 2'd0);
    end

    assign bus.ACT = act_q | str_on;
`else
    assign bus.ACT = act_q;
`endif

    assign bus.LOC         = loc_q;
    assign bus.FAIL        = fail_q;
    assign bus.FRAME_VALID = fv_q;
    assign bus.LINK_UP     = link_q;
    assign bus.ERR_CNT     = err_q;
endmodule
